fxp_unit: RTL and testbench

- Parametrised, handshaked successor to the 64-bit Q15 fixed-point unit.
- Computes signed fixed-point multiply-add variants, division, and square root, with saturation and exception flags.
- Uses valid/ready on input and output, with one operation outstanding at a time.
- Sits between the issue stage and writeback of the ray/shading datapath; backpressure comes from writeback.

---
 rtl/fxp_pkg.sv | 47 ++++
 rtl/fxp_iter_core.sv | 87 ++++++++
 rtl/fxp_unit.sv | 177 +++++++++++++++++
 tb/tb_fxp_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared definitions for the handshaked fixed-point unit: opcodes, flag
// positions, FSM encodings and the clamp helper used by the MAD and DIV paths.
package fxp_pkg;

    localparam int MAX_WIDTH = 64;
    // Wide enough for a (2*WIDTH+2)-bit product plus a WIDTH-bit addend at MAX_WIDTH
    localparam int ACC_BITS  = 2 * MAX_WIDTH + 3;

    localparam logic [2:0] OP_MAD_PP = 3'b000;
    localparam logic [2:0] OP_MAD_PN = 3'b001;
    localparam logic [2:0] OP_MAD_NP = 3'b010;
    localparam logic [2:0] OP_MAD_NN = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_SQRT   = 3'b101;

    localparam int FLAG_SAT  = 0;
    localparam int FLAG_DIV0 = 1;
    localparam int FLAG_INV  = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] ITER    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic MODE_DIV  = 1'b0;
    localparam logic MODE_SQRT = 1'b1;

    // Clamps a wide signed value into a signed field of 'width' bits; the top bit
    // of the return value is the saturation indication, the rest the clamped value.
    function automatic logic [MAX_WIDTH:0] saturate(input logic signed [ACC_BITS-1:0] value,
                                                    input int unsigned width);
        logic signed [ACC_BITS-1:0] max_v;
        logic signed [ACC_BITS-1:0] min_v;
        logic [MAX_WIDTH:0] res;
        max_v = (ACC_BITS'(1) << (width - 1)) - ACC_BITS'(1);
        min_v = ~max_v;
        if (value > max_v) begin
            res = {1'b1, max_v[MAX_WIDTH-1:0]};
        end else if (value < min_v) begin
            res = {1'b1, min_v[MAX_WIDTH-1:0]};
        end else begin
            res = {1'b0, value[MAX_WIDTH-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp_iter_core.sv
// Shift-subtract engine shared by restoring division and digit-by-digit square
// root; works purely on unsigned magnitudes and produces one result bit per step.
module fxp_iter_core
    import fxp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    step,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        a_mag,
    input  logic [WIDTH-1:0]        b_mag,
    output logic                    done,
    output logic [WIDTH+FRAC-1:0]   result
);

    localparam int QW         = WIDTH + FRAC;
    localparam int SQRT_STEPS = (QW + 1) / 2;
    localparam int DATA_W     = 2 * SQRT_STEPS;
    // The square-root remainder never exceeds SQRT_STEPS+2 bits, which is <= WIDTH+1
    localparam int REM_W      = WIDTH + 1;
    localparam int CNT_W      = $clog2(QW + 1);

    logic                mode_q;
    logic [DATA_W-1:0]   x_q;
    logic [REM_W-1:0]    rem_q;
    logic [QW-1:0]       q_q;
    logic [WIDTH-1:0]    div_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_W-1:0]   load_x;
    logic [REM_W-1:0]    rem_shift;
    logic [REM_W-1:0]    subtrahend;
    logic [REM_W:0]      diff;
    logic                take;

    // Dividend and radicand are both |A|<<FRAC; division consumes it MSB-first one
    // bit at a time, so it is left-aligned, while the root eats aligned bit pairs.
    always_comb begin
        load_x = DATA_W'(a_mag) << FRAC;
        if (mode == MODE_DIV) begin
            load_x = load_x << (DATA_W - QW);
        end
    end

    always_comb begin
        if (mode_q == MODE_SQRT) begin
            rem_shift  = {rem_q[REM_W-3:0], x_q[DATA_W-1 -: 2]};
            subtrahend = REM_W'({q_q[SQRT_STEPS-1:0], 2'b01});
        end else begin
            rem_shift  = {rem_q[REM_W-2:0], x_q[DATA_W-1]};
            subtrahend = REM_W'(div_q);
        end
        diff = {1'b0, rem_shift} - {1'b0, subtrahend};
        take = !diff[REM_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_DIV;
            x_q    <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            mode_q <= mode;
            x_q    <= load_x;
            rem_q  <= '0;
            q_q    <= '0;
            div_q  <= b_mag;
            cnt_q  <= (mode == MODE_SQRT) ? CNT_W'(SQRT_STEPS) : CNT_W'(QW);
        end else if (step && (cnt_q != '0)) begin
            x_q   <= (mode_q == MODE_SQRT) ? (x_q << 2) : (x_q << 1);
            rem_q <= take ? diff[REM_W-1:0] : rem_shift;
            q_q   <= {q_q[QW-2:0], take};
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done   = (cnt_q == '0);
    assign result = q_q;

endmodule

// File: rtl/fxp_unit.sv
// Handshaked signed Q-format unit: multiply-add variants, division and square
// root with saturation and exception flags, one operation in flight at a time.
module fxp_unit
    import fxp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [WIDTH-1:0]    in_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_res,
    output logic [2:0]          out_flags
);

    localparam int PW = 2 * WIDTH + 2;
    localparam int QW = WIDTH + FRAC;

    logic [1:0]          state_q;
    logic [2:0]          op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    c_q;

    logic                accept;
    logic                go_iter;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic                core_start;
    logic                core_step;
    logic                core_done;
    logic [QW-1:0]       core_result;

    logic signed [WIDTH:0]          mad_a;
    logic signed [WIDTH:0]          mad_b;
    logic signed [PW-1:0]           mad_prod;
    logic signed [PW-1:0]           mad_shift;
    logic signed [ACC_BITS-1:0]     prod_acc;
    logic signed [ACC_BITS-1:0]     c_acc;
    logic signed [ACC_BITS-1:0]     mad_sum;
    logic [MAX_WIDTH:0]             mad_sat;
    logic signed [ACC_BITS-1:0]     div_acc;
    logic [MAX_WIDTH:0]             div_sat;

    logic [WIDTH-1:0]    fast_res;
    logic [2:0]          fast_flags;
    logic [WIDTH-1:0]    iter_res;
    logic [2:0]          iter_flags;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // Only well-formed DIV/SQRT go through the iterative engine; everything else
    // (including the exception cases) is resolved in a single COMPUTE cycle.
    assign go_iter    = ((in_op == OP_DIV) && (in_b != '0)) ||
                        ((in_op == OP_SQRT) && !in_a[WIDTH-1]);
    assign a_mag      = in_a[WIDTH-1] ? -in_a : in_a;
    assign b_mag      = in_b[WIDTH-1] ? -in_b : in_b;
    assign core_start = accept && go_iter;
    assign core_step  = (state_q == ITER) && !core_done;

    fxp_iter_core #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_iter_core (
        .clk    (clk),
        .reset  (reset),
        .start  (core_start),
        .step   (core_step),
        .mode   ((in_op == OP_SQRT) ? MODE_SQRT : MODE_DIV),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .done   (core_done),
        .result (core_result)
    );

    // Operand A is widened by one bit before negation so that -min is representable
    always_comb begin
        mad_a = {a_q[WIDTH-1], a_q};
        if (op_q[1]) begin
            mad_a = -mad_a;
        end
        mad_b     = {b_q[WIDTH-1], b_q};
        mad_prod  = {{(WIDTH+1){mad_a[WIDTH]}}, mad_a} * {{(WIDTH+1){mad_b[WIDTH]}}, mad_b};
        mad_shift = mad_prod >>> FRAC;
        prod_acc  = {{(ACC_BITS-PW){mad_shift[PW-1]}}, mad_shift};
        c_acc     = {{(ACC_BITS-WIDTH){c_q[WIDTH-1]}}, c_q};
        mad_sum   = op_q[0] ? (prod_acc - c_acc) : (prod_acc + c_acc);
        mad_sat   = saturate(mad_sum, WIDTH);
    end

    always_comb begin
        fast_res   = '0;
        fast_flags = '0;
        case (op_q)
            OP_MAD_PP, OP_MAD_PN, OP_MAD_NP, OP_MAD_NN: begin
                fast_res             = mad_sat[WIDTH-1:0];
                fast_flags[FLAG_SAT] = mad_sat[MAX_WIDTH];
            end
            OP_DIV: begin
                fast_res              = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
                fast_flags[FLAG_SAT]  = 1'b1;
                fast_flags[FLAG_DIV0] = 1'b1;
            end
            default: begin
                fast_flags[FLAG_INV] = 1'b1;
            end
        endcase
    end

    always_comb begin
        div_acc = ACC_BITS'(core_result);
        if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
            div_acc = -div_acc;
        end
        div_sat    = saturate(div_acc, WIDTH);
        iter_flags = '0;
        if (op_q == OP_SQRT) begin
            iter_res = core_result[WIDTH-1:0];
        end else begin
            iter_res             = div_sat[WIDTH-1:0];
            iter_flags[FLAG_SAT] = div_sat[MAX_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            out_res   <= '0;
            out_flags <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= in_op;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        c_q     <= in_c;
                        state_q <= go_iter ? ITER : COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_res   <= fast_res;
                    out_flags <= fast_flags;
                    state_q   <= DONE;
                end
                ITER: begin
                    if (core_done) begin
                        out_res   <= iter_res;
                        out_flags <= iter_flags;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_unit.sv
// Directed bench for fxp_unit at WIDTH=64, FRAC=15 (1.0 = 32768) with
// hand-computed results, latencies, backpressure and mid-operation reset.
module tb_fxp_unit;

    localparam int WIDTH = 64;
    localparam int FRAC  = 15;

    localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] TWO_62  = 64'h4000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   in_c;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_res;
    logic [2:0]         out_flags;

    int check_count = 0;
    int error_count = 0;

    fxp_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=0x%h expected=0x%h", tag, actual, expected);
        end
    endtask

    // Issues one request and waits for its result without retiring it
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] c,
                                 input logic [63:0] exp_res, input logic [2:0] exp_flags,
                                 input int exp_lat);
        int waited;
        int lat;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_res"}, out_res, exp_res);
        checkOutput({tag, "_flags"}, 64'(out_flags), 64'(exp_flags));
    endtask

    task automatic retireResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_retired"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] held_res;
        logic [2:0]  held_flags;
        int          stale;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_res", out_res, 64'd0);
        checkOutput("reset_flags", 64'(out_flags), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

        applyStimulus("mad_pp", 3'b000, 64'd49152, 64'd65536, 64'd8192, 64'd106496, 3'b000, 2);
        retireResult("mad_pp");
        applyStimulus("mad_nn", 3'b011, 64'd49152, 64'd65536, 64'd8192, -64'd106496, 3'b000, 2);
        retireResult("mad_nn");
        applyStimulus("div_pos", 3'b100, 64'd32768, 64'd98304, 64'd0, 64'd10922, 3'b000, 81);
        retireResult("div_pos");
        applyStimulus("div_neg", 3'b100, -64'd32768, 64'd98304, 64'd0, -64'd10922, 3'b000, 81);
        retireResult("div_neg");
        applyStimulus("sqrt_4", 3'b101, 64'd131072, 64'd0, 64'd0, 64'd65536, 3'b000, 42);
        retireResult("sqrt_4");
        applyStimulus("sqrt_neg", 3'b101, -64'd1, 64'd0, 64'd0, 64'd0, 3'b100, 2);
        retireResult("sqrt_neg");
        applyStimulus("reserved", 3'b110, 64'd5, 64'd7, 64'd9, 64'd0, 3'b100, 2);
        retireResult("reserved");
        applyStimulus("div0_pos", 3'b100, 64'd32768, 64'd0, 64'd0, MAX_POS, 3'b011, 2);
        retireResult("div0_pos");
        applyStimulus("div0_neg", 3'b100, -64'd32768, 64'd0, 64'd0, MIN_NEG, 3'b011, 2);
        retireResult("div0_neg");
        applyStimulus("mad_sat_pos", 3'b000, TWO_62, TWO_62, 64'd0, MAX_POS, 3'b001, 2);
        retireResult("mad_sat_pos");
        applyStimulus("mad_sat_neg", 3'b010, TWO_62, TWO_62, 64'd0, MIN_NEG, 3'b001, 2);
        retireResult("mad_sat_neg");

        // Backpressure: result and flags must hold while out_ready stays low
        applyStimulus("bp", 3'b001, 64'd98304, 64'd32768, 64'd16384, 64'd81920, 3'b000, 2);
        held_res   = out_res;
        held_flags = out_flags;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_res", out_res, 64'd81920);
            checkOutput("bp_hold_flags", 64'(out_flags), 64'(held_flags));
            checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        checkOutput("bp_held_res_start", held_res, 64'd81920);
        in_op     = 3'b000;
        in_a      = 64'd32768;
        in_b      = 64'd32768;
        in_c      = 64'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp_retire_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_retire_not_accepted", 64'(in_ready), 64'd1);

        // Reset in the middle of a division: no result may surface afterwards
        in_op    = 3'b100;
        in_a     = 64'd32768;
        in_b     = 64'd98304;
        in_c     = 64'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midop_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midop_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("midop_reset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("midop_ready_after_reset", 64'(in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("midop_no_stale", 64'(stale), 64'd0);
        applyStimulus("after_reset_mad", 3'b000, 64'd49152, 64'd65536, 64'd8192, 64'd106496, 3'b000, 2);
        retireResult("after_reset_mad");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
